// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin arbiter sequencing one shared 32-bit ALU
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req{0,1}_valid/ready             request handshake (ready asserts only in IDLE)
//   req{0,1}_a, req{0,1}_b           32-bit operands
//   req{0,1}_ctrl                    ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//   rsp{0,1}_valid/ready             response handshake, only the owner's valid rises
//   rsp{0,1}_y, rsp{0,1}_zero        registered result and zero flag
//   busy                             high whenever a transaction is in flight
module alu_arbiter #(
   parameter logic RR_INIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [2:0]  req0_ctrl,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [2:0]  req1_ctrl,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_y,
   output logic        rsp0_zero,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_y,
   output logic        rsp1_zero,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state, state_nx;
   logic        prio;
   logic        owner;
   logic [31:0] a_q, b_q, y_q;
   logic [2:0]  ctrl_q;
   logic        zero_q;
   logic [31:0] alu_y;
   logic        grant0, grant1, take, give;

   // Shared ALU, fed only from the latched operands.
   always_comb begin
      alu_y = 32'd0;
      case (ctrl_q)
         3'b000:  alu_y = a_q & b_q;
         3'b001:  alu_y = a_q | b_q;
         3'b010:  alu_y = a_q + b_q;
         3'b110:  alu_y = a_q - b_q;
         3'b111:  alu_y = {31'd0, $signed(a_q) < $signed(b_q)};
         default: alu_y = 32'd0;
      endcase
   end

   always_comb begin
      state_nx = state;
      grant0   = 1'b0;
      grant1   = 1'b0;
      take     = 1'b0;
      give     = 1'b0;
      case (state)
         IDLE: begin
            // A lone requester wins outright; prio only breaks a tie.
            if (!rst) begin
               grant0 = req0_valid && (!req1_valid || !prio);
               grant1 = req1_valid && (!req0_valid ||  prio);
            end
            take = grant0 || grant1;
            if (take) state_nx = EXEC;
         end
         EXEC: state_nx = RESP;
         RESP: begin
            give = owner ? rsp1_ready : rsp0_ready;
            if (give) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         prio   <= RR_INIT;
         owner  <= 1'b0;
         a_q    <= 32'd0;
         b_q    <= 32'd0;
         ctrl_q <= 3'd0;
         y_q    <= 32'd0;
         zero_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (take) begin
            owner  <= grant1;
            a_q    <= grant1 ? req1_a    : req0_a;
            b_q    <= grant1 ? req1_b    : req0_b;
            ctrl_q <= grant1 ? req1_ctrl : req0_ctrl;
         end
         if (state == EXEC) begin
            y_q    <= alu_y;
            zero_q <= (alu_y == 32'd0);
         end
         // Priority moves to the other port only once a response is consumed.
         if (give) prio <= ~owner;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign rsp0_valid = (state == RESP) && !owner;
   assign rsp1_valid = (state == RESP) &&  owner;
   assign rsp0_y     = y_q;
   assign rsp1_y     = y_q;
   assign rsp0_zero  = zero_q;
   assign rsp1_zero  = zero_q;
   assign busy       = (state != IDLE);

endmodule
